// File: rtl/kyber_butterfly_seq_if.sv
// Port bundle between the butterfly sequencer, its upstream fetch logic,
// its downstream consumer and the shared modular arithmetic unit.
interface kyber_butterfly_seq_if;
  logic        i_valid;
  logic        o_ready;
  logic        i_inv;
  logic [11:0] i_a;
  logic [11:0] i_b;
  logic [11:0] i_zeta;
  logic        o_valid;
  logic        i_ready;
  logic [11:0] o_a;
  logic [11:0] o_b;
  logic [11:0] o_ar_a;
  logic [11:0] o_ar_b;
  logic [1:0]  o_ar_morb;
  logic        o_ar_en;
  logic [11:0] i_ar_c;
  logic        i_ar_done;

  modport slave (
    input  i_valid, i_inv, i_a, i_b, i_zeta, i_ready, i_ar_c, i_ar_done,
    output o_ready, o_valid, o_a, o_b, o_ar_a, o_ar_b, o_ar_morb, o_ar_en
  );

  modport master (
    output i_valid, i_inv, i_a, i_b, i_zeta, i_ready, i_ar_c, i_ar_done,
    input  o_ready, o_valid, o_a, o_b, o_ar_a, o_ar_b, o_ar_morb, o_ar_en
  );
endinterface

// File: rtl/kyber_butterfly_seq.sv
// Sequences one CT/GS butterfly as three ops on a shared arithmetic unit.
// Result valid 1 + sum(1+L_k) cycles after accept; result held while i_ready is low.
module kyber_butterfly_seq #(
  parameter int         KYBER_Q  = 3329,
  parameter logic [1:0] MODE_MUL = 2'b10,
  parameter logic [1:0] MODE_ADD = 2'b01,
  parameter logic [1:0] MODE_SUB = 2'b00
) (
  input logic                  i_clk,
  input logic                  i_rst,
  kyber_butterfly_seq_if.slave bus
);

  localparam int DW = $clog2(KYBER_Q);

  typedef enum logic [2:0] {
    IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, ISSUE3, WAIT3, OUT
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_zeta;
  logic            r_inv;
  logic [DW-1:0]   r_t;
  logic [DW-1:0]   r_oa;
  logic [DW-1:0]   r_ob;
  logic [DW-1:0]   r_ar_a;
  logic [DW-1:0]   r_ar_b;
  logic [1:0]      r_ar_morb;
  logic            r_ar_en;
  logic            r_valid;
  logic            r_ready;

  // Operands for op k+1 are registered on the edge that leaves WAITk, so an
  // op result that feeds the next op is taken straight from i_ar_c.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_zeta    <= '0;
      r_inv     <= 1'b0;
      r_t       <= '0;
      r_oa      <= '0;
      r_ob      <= '0;
      r_ar_a    <= '0;
      r_ar_b    <= '0;
      r_ar_morb <= '0;
      r_ar_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_ar_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_zeta  <= bus.i_zeta;
            r_inv   <= bus.i_inv;
            r_ready <= 1'b0;
            r_ar_en <= 1'b1;
            r_state <= ISSUE1;
            if (bus.i_inv) begin
              r_ar_a    <= bus.i_a;
              r_ar_b    <= bus.i_b;
              r_ar_morb <= MODE_ADD;
            end else begin
              r_ar_a    <= bus.i_zeta;
              r_ar_b    <= bus.i_b;
              r_ar_morb <= MODE_MUL;
            end
          end
        end
        ISSUE1: r_state <= WAIT1;
        WAIT1: begin
          if (bus.i_ar_done) begin
            r_ar_en <= 1'b1;
            r_state <= ISSUE2;
            if (r_inv) begin
              r_oa      <= bus.i_ar_c;
              r_ar_a    <= r_b;
              r_ar_b    <= r_a;
              r_ar_morb <= MODE_SUB;
            end else begin
              r_t       <= bus.i_ar_c;
              r_ar_a    <= r_a;
              r_ar_b    <= bus.i_ar_c;
              r_ar_morb <= MODE_ADD;
            end
          end
        end
        ISSUE2: r_state <= WAIT2;
        WAIT2: begin
          if (bus.i_ar_done) begin
            r_ar_en <= 1'b1;
            r_state <= ISSUE3;
            if (r_inv) begin
              r_t       <= bus.i_ar_c;
              r_ar_a    <= r_zeta;
              r_ar_b    <= bus.i_ar_c;
              r_ar_morb <= MODE_MUL;
            end else begin
              r_oa      <= bus.i_ar_c;
              r_ar_a    <= r_a;
              r_ar_b    <= r_t;
              r_ar_morb <= MODE_SUB;
            end
          end
        end
        ISSUE3: r_state <= WAIT3;
        WAIT3: begin
          if (bus.i_ar_done) begin
            r_ob      <= bus.i_ar_c;
            r_ar_a    <= '0;
            r_ar_b    <= '0;
            r_ar_morb <= '0;
            r_valid   <= 1'b1;
            r_state   <= OUT;
          end
        end
        OUT: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready   = r_ready;
  assign bus.o_valid   = r_valid;
  assign bus.o_a       = r_oa;
  assign bus.o_b       = r_ob;
  assign bus.o_ar_a    = r_ar_a;
  assign bus.o_ar_b    = r_ar_b;
  assign bus.o_ar_morb = r_ar_morb;
  assign bus.o_ar_en   = r_ar_en;

endmodule

// File: tb/tb_kyber_butterfly_seq.sv
// Bench for kyber_butterfly_seq: arithmetic-unit model plus butterfly reference.
module tb_kyber_butterfly_seq;
  localparam int Q = 3329;
  localparam int M_MUL = 2, M_ADD = 1, M_SUB = 0;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  kyber_butterfly_seq_if bus ();

  kyber_butterfly_seq dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int rinv;
  function automatic int mont(input int a, input int b);
    return ((a * b) % Q) * rinv % Q;
  endfunction

  // Arithmetic-unit model: MUL latency 4, ADD/SUB latency 1
  int cnt = 0;
  bit spurious = 0;
  bit abort = 0;
  int m_a, m_b, m_mode;
  int q_mode[$], q_a[$], q_b[$];

  always @(negedge i_clk) begin
    bus.i_ar_done = 1'b0;
    if (cnt > 0) begin
      if (!abort) begin
        chk("hold_ar_a", bus.o_ar_a, m_a);
        chk("hold_ar_b", bus.o_ar_b, m_b);
        chk("hold_mode", bus.o_ar_morb, m_mode);
        chk("wait_en", bus.o_ar_en, 0);
      end
      cnt--;
      if (cnt == 0) begin
        abort = 0;
        bus.i_ar_done = 1'b1;
        case (m_mode)
          M_MUL:   bus.i_ar_c = 12'(mont(m_a, m_b));
          M_ADD:   bus.i_ar_c = 12'((m_a + m_b) % Q);
          default: bus.i_ar_c = 12'((m_a - m_b + Q) % Q);
        endcase
      end
    end
    if (bus.o_ar_en === 1'b1) begin
      m_a = int'(bus.o_ar_a);
      m_b = int'(bus.o_ar_b);
      m_mode = int'(bus.o_ar_morb);
      q_mode.push_back(m_mode);
      q_a.push_back(m_a);
      q_b.push_back(m_b);
      cnt = (m_mode == M_MUL) ? 4 : 1;
      if (spurious) begin
        bus.i_ar_done = 1'b1;
        bus.i_ar_c = 12'($urandom_range(0, Q - 1));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (bus.o_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  // One butterfly; exp_oa/exp_ob < 0 means take the reference-model value
  task automatic run(input bit inv, input int a, input int b, input int z,
                     input int exp_oa, input int exp_ob, input int hold, input bit junk);
    int t0, t, n, oa, ob;
    int em[3], ea[3], eb[3];
    if (inv) begin
      oa = (a + b) % Q;
      t  = (b - a + Q) % Q;
      ob = mont(z, t);
      em = '{M_ADD, M_SUB, M_MUL}; ea = '{a, b, z}; eb = '{b, a, t};
    end else begin
      t  = mont(z, b);
      oa = (a + t) % Q;
      ob = (a - t + Q) % Q;
      em = '{M_MUL, M_ADD, M_SUB}; ea = '{z, a, a}; eb = '{b, t, t};
    end
    if (exp_oa >= 0) oa = exp_oa;
    if (exp_ob >= 0) ob = exp_ob;
    wait_ready();
    q_mode.delete(); q_a.delete(); q_b.delete();
    bus.i_inv = inv; bus.i_a = 12'(a); bus.i_b = 12'(b); bus.i_zeta = 12'(z);
    bus.i_valid = 1'b1;
    t0 = cyc;
    @(negedge i_clk);
    chk("busy_ready", bus.o_ready, 0);
    bus.i_valid = junk;
    n = 0;
    while (bus.o_valid !== 1'b1 && n < 100) begin
      if (junk) begin
        bus.i_inv = 1'($urandom); bus.i_a = 12'($urandom_range(0, Q - 1));
        bus.i_b = 12'($urandom_range(0, Q - 1)); bus.i_zeta = 12'($urandom_range(0, Q - 1));
      end
      @(negedge i_clk);
      n++;
    end
    bus.i_valid = 1'b0;
    if (bus.o_valid !== 1'b1) begin
      chk("valid_timeout", 0, 1);
      return;
    end
    chk("latency", cyc - t0, 10);
    chk("o_a", bus.o_a, oa);
    chk("o_b", bus.o_b, ob);
    chk("ar_a_out", bus.o_ar_a, 0);
    chk("ar_b_out", bus.o_ar_b, 0);
    chk("mode_out", bus.o_ar_morb, 0);
    chk("n_ops", q_mode.size(), 3);
    if (q_mode.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk("op_mode", q_mode[k], em[k]);
        chk("op_a", q_a[k], ea[k]);
        chk("op_b", q_b[k], eb[k]);
      end
    if (hold > 0) begin
      bus.i_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge i_clk);
        chk("bp_valid", bus.o_valid, 1);
        chk("bp_o_a", bus.o_a, oa);
        chk("bp_o_b", bus.o_b, ob);
        chk("bp_ready", bus.o_ready, 0);
      end
      bus.i_ready = 1'b1;
    end
    @(negedge i_clk);
    chk("post_valid", bus.o_valid, 0);
    chk("post_ready", bus.o_ready, 1);
  endtask

  initial begin
    rinv = 0;
    for (int x = 1; x < Q; x++)
      if ((4096 * x) % Q == 1) rinv = x;
    i_rst = 1'b1;
    bus.i_valid = 0; bus.i_inv = 0; bus.i_a = 0; bus.i_b = 0; bus.i_zeta = 0;
    bus.i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", bus.o_ready, 1);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready_post", bus.o_ready, 1);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_en", bus.o_ar_en, 0);
    chk("rst_mode", bus.o_ar_morb, 0);
    chk("rst_ar_a", bus.o_ar_a, 0);
    chk("rst_ar_b", bus.o_ar_b, 0);
    chk("rst_o_a", bus.o_a, 0);
    chk("rst_o_b", bus.o_b, 0);

    run(0, 100, 200, 767, 300, 3229, 7, 0);
    run(1, 100, 200, 767, 300, 100, 0, 0);
    run(0, 3000, 1000, 767, 671, 2000, 0, 0);
    run(0, 5, 9, 0, 5, 5, 2, 0);
    run(0, 1234, 2345, 17, -1, -1, 0, 1);

    spurious = 1;
    for (int i = 0; i < 4; i++)
      run(1'(i), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
          $urandom_range(0, Q - 1), -1, -1, 0, 0);
    spurious = 0;

    // Abort during WAIT1; the unit's late done must be discarded
    wait_ready();
    bus.i_inv = 0; bus.i_a = 12'd7; bus.i_b = 12'd8; bus.i_zeta = 12'd767;
    bus.i_valid = 1'b1;
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    abort = 1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_ready", bus.o_ready, 1);
    chk("abort_en", bus.o_ar_en, 0);
    chk("abort_valid", bus.o_valid, 0);
    chk("abort_o_a", bus.o_a, 0);
    chk("abort_o_b", bus.o_b, 0);
    chk("abort_ar_a", bus.o_ar_a, 0);
    chk("abort_ar_b", bus.o_ar_b, 0);
    chk("abort_mode", bus.o_ar_morb, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("idle_valid", bus.o_valid, 0);
      chk("idle_en", bus.o_ar_en, 0);
      chk("idle_ready", bus.o_ready, 1);
    end
    run(0, 100, 200, 767, 300, 3229, 0, 0);

    for (int i = 0; i < 20; i++) begin
      spurious = 1'($urandom);
      run(1'($urandom), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
          $urandom_range(0, Q - 1), -1, -1, $urandom_range(0, 3), 1'($urandom));
    end
    spurious = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
